// File: rtl/sdram_refresh_sched.sv
// SDRAM housekeeping scheduler: power-up sequence, then periodic AUTO REFRESH requests with a bounded backlog.
// Optional statistics outputs (RefCount, OvfCount) are enabled by defining SDRAM_REF_STATS_EN.
module sdram_refresh_sched #(
  parameter int unsigned INIT_TICKS     = 200,
  parameter int unsigned REF_TICKS      = 78,
  parameter int unsigned INIT_REFRESHES = 8,
  parameter int unsigned MAX_PENDING    = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        ClkIn,
  input  logic        Reset,
  input  logic        TickIn,
  output logic        CmdReq,
  output logic [1:0]  CmdCode,
  input  logic        CmdAck,
  output logic        InitDone,
  output logic [3:0]  Pending,
  output logic        Urgent,
  output logic        Overflow
`ifdef SDRAM_REF_STATS_EN
  ,
  output logic [31:0] RefCount,
  output logic [15:0] OvfCount
`endif
);

  localparam int unsigned RC_W = $clog2(INIT_REFRESHES) + 1;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_PRECHARGE,
    S_INIT_REF,
    S_LOAD_MODE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'b00,
    CMD_PRECHARGE = 2'b01,
    CMD_REFRESH   = 2'b10,
    CMD_LOAD_MODE = 2'b11
  } cmd_t;

  state_t           r_state;
  cmd_t             r_cmd_code;
  logic             r_cmd_req;
  logic             r_init_done;
  logic [3:0]       r_pending;
  logic             r_urgent;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic [RC_W-1:0]  r_refcnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_tick;

  logic             w_accept;
  logic             w_due;
  logic             w_drop;
  logic [3:0]       w_pending_nxt;

  assign w_accept = r_cmd_req & CmdAck;
  assign w_due    = (r_state == S_RUN) & r_tick & (r_cnt == CNT_W'(REF_TICKS - 1));
  assign w_drop   = w_due & ~w_accept & (r_pending == 4'(MAX_PENDING));

  // A due refresh and an accept in the same cycle cancel each other out.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_due && !w_accept && (r_pending != 4'(MAX_PENDING))) begin
      w_pending_nxt = r_pending + 4'd1;
    end else if (w_accept && !w_due && (r_pending != '0)) begin
      w_pending_nxt = r_pending - 4'd1;
    end
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      r_state     <= S_WAIT_INIT;
      r_cmd_code  <= CMD_NONE;
      r_cmd_req   <= 1'b0;
      r_init_done <= 1'b0;
      r_pending   <= '0;
      r_urgent    <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt       <= '0;
      r_refcnt    <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sync1 <= TickIn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;

      case (r_state)
        S_WAIT_INIT: begin
          if (r_tick) begin
            if (r_cnt == CNT_W'(INIT_TICKS - 1)) begin
              r_cnt      <= '0;
              r_state    <= S_PRECHARGE;
              r_cmd_req  <= 1'b1;
              r_cmd_code <= CMD_PRECHARGE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_PRECHARGE: begin
          if (w_accept) begin
            r_cmd_req  <= 1'b0;
            r_cmd_code <= CMD_NONE;
            r_refcnt   <= '0;
            r_state    <= S_INIT_REF;
          end else if (!r_cmd_req) begin
            r_cmd_req  <= 1'b1;
            r_cmd_code <= CMD_PRECHARGE;
          end
        end

        S_INIT_REF: begin
          if (w_accept) begin
            r_cmd_req  <= 1'b0;
            r_cmd_code <= CMD_NONE;
            if (r_refcnt == RC_W'(INIT_REFRESHES - 1)) begin
              r_state <= S_LOAD_MODE;
            end else begin
              r_refcnt <= r_refcnt + 1'b1;
            end
          end else if (!r_cmd_req) begin
            r_cmd_req  <= 1'b1;
            r_cmd_code <= CMD_REFRESH;
          end
        end

        S_LOAD_MODE: begin
          if (w_accept) begin
            r_cmd_req   <= 1'b0;
            r_cmd_code  <= CMD_NONE;
            r_init_done <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RUN;
          end else if (!r_cmd_req) begin
            r_cmd_req  <= 1'b1;
            r_cmd_code <= CMD_LOAD_MODE;
          end
        end

        S_RUN: begin
          if (r_tick) begin
            r_cnt <= w_due ? '0 : r_cnt + 1'b1;
          end
          r_pending <= w_pending_nxt;
          r_urgent  <= (w_pending_nxt >= 4'(MAX_PENDING - 1));
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
          // The accept cycle always forces one idle cycle before the next request.
          if (!w_accept && (w_pending_nxt != '0)) begin
            r_cmd_req  <= 1'b1;
            r_cmd_code <= CMD_REFRESH;
          end else begin
            r_cmd_req  <= 1'b0;
            r_cmd_code <= CMD_NONE;
          end
        end

        default: begin
          r_state    <= S_WAIT_INIT;
          r_cmd_req  <= 1'b0;
          r_cmd_code <= CMD_NONE;
        end
      endcase
    end
  end

  assign CmdReq   = r_cmd_req;
  assign CmdCode  = r_cmd_code;
  assign InitDone = r_init_done;
  assign Pending  = r_pending;
  assign Urgent   = r_urgent;
  assign Overflow = r_overflow;

`ifdef SDRAM_REF_STATS_EN
  logic [31:0] r_ref_count;
  logic [15:0] r_ovf_count;

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      r_ref_count <= '0;
      r_ovf_count <= '0;
    end else begin
      if ((r_state == S_RUN) && w_accept && (r_ref_count != '1)) begin
        r_ref_count <= r_ref_count + 32'd1;
      end
      if (w_drop && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + 16'd1;
      end
    end
  end

  assign RefCount = r_ref_count;
  assign OvfCount = r_ovf_count;
`endif

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Randomized bench for sdram_refresh_sched against a queue/arithmetic reference model.
// Defining SDRAM_REF_STATS_EN also checks the statistics outputs.
module tb_sdram_refresh_sched;

  localparam int INIT_TICKS     = 200;
  localparam int REF_TICKS      = 78;
  localparam int INIT_REFRESHES = 8;
  localparam int MAX_PENDING    = 8;
  localparam int CNT_W          = 16;

  logic       ClkIn = 1'b0;
  logic       Reset = 1'b1;
  logic       TickIn = 1'b0;
  logic       CmdAck = 1'b0;
  logic       CmdReq;
  logic [1:0] CmdCode;
  logic       InitDone;
  logic [3:0] Pending;
  logic       Urgent;
  logic       Overflow;
`ifdef SDRAM_REF_STATS_EN
  logic [31:0] RefCount;
  logic [15:0] OvfCount;
`endif

  sdram_refresh_sched #(
    .INIT_TICKS     (INIT_TICKS),
    .REF_TICKS      (REF_TICKS),
    .INIT_REFRESHES (INIT_REFRESHES),
    .MAX_PENDING    (MAX_PENDING),
    .CNT_W          (CNT_W)
  ) dut (
    .ClkIn    (ClkIn),
    .Reset    (Reset),
    .TickIn   (TickIn),
    .CmdReq   (CmdReq),
    .CmdCode  (CmdCode),
    .CmdAck   (CmdAck),
    .InitDone (InitDone),
    .Pending  (Pending),
    .Urgent   (Urgent),
    .Overflow (Overflow)
`ifdef SDRAM_REF_STATS_EN
    ,
    .RefCount (RefCount),
    .OvfCount (OvfCount)
`endif
  );

  always #5 ClkIn = ~ClkIn;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ticks are derived from the TickIn samples seen at each edge,
  // the init sequence is a queue of commands, RUN is arithmetic on tick counts.
  bit [3:0] hist;
  bit       m_wait = 1'b1;
  bit       m_run = 1'b0;
  int       m_ticks = 0;
  int       cmdq[$];
  int       acc_log[$];
  bit       m_req = 1'b0;
  int       m_code = 0;
  bit       m_done = 1'b0;
  int       m_pend = 0;
  bit       m_ovf = 1'b0;
  int       m_dues = 0;
  int       m_refs = 0;
  int       m_ovfs = 0;
  int       tick_left = 3;

  task automatic step();
    logic       rst_s, t_s, a_s, dreq;
    logic [1:0] dcode;
    bit         tk, acc, due;
    rst_s = Reset;
    t_s   = TickIn;
    a_s   = CmdAck;
    dreq  = CmdReq;
    dcode = CmdCode;
    @(posedge ClkIn);
    #1;
    if (rst_s) begin
      hist    = '0;
      m_wait  = 1'b1;
      m_run   = 1'b0;
      m_ticks = 0;
      cmdq.delete();
      acc_log.delete();
      m_req   = 1'b0;
      m_code  = 0;
      m_done  = 1'b0;
      m_pend  = 0;
      m_ovf   = 1'b0;
      m_refs  = 0;
      m_ovfs  = 0;
    end else begin
      if (dreq && a_s && !m_run) acc_log.push_back(int'(dcode));
      tk   = hist[2] && !hist[3];
      hist = {hist[2:0], t_s};
      acc  = m_req && a_s;
      if (m_wait) begin
        if (tk) begin
          m_ticks++;
          if (m_ticks == INIT_TICKS) begin
            m_wait = 1'b0;
            cmdq.push_back(1);
            for (int i = 0; i < INIT_REFRESHES; i++) cmdq.push_back(2);
            cmdq.push_back(3);
            m_req  = 1'b1;
            m_code = cmdq[0];
          end
        end
      end else if (!m_run) begin
        if (acc) begin
          void'(cmdq.pop_front());
          m_req  = 1'b0;
          m_code = 0;
          if (cmdq.size() == 0) begin
            m_run   = 1'b1;
            m_done  = 1'b1;
            m_ticks = 0;
          end
        end else if (!m_req) begin
          m_req  = 1'b1;
          m_code = cmdq[0];
        end
      end else begin
        due = 1'b0;
        if (tk) begin
          m_ticks++;
          due = (m_ticks % REF_TICKS) == 0;
        end
        if (due) m_dues++;
        if (due && !acc) begin
          if (m_pend < MAX_PENDING) m_pend++;
          else begin
            m_ovf = 1'b1;
            m_ovfs++;
          end
        end else if (acc && !due) begin
          m_pend--;
        end
        if (acc) m_refs++;
        m_req  = !acc && (m_pend != 0);
        m_code = m_req ? 2 : 0;
      end
    end

    check("CmdReq", 32'(CmdReq), 32'(m_req));
    if (m_req || m_wait || m_run) check("CmdCode", 32'(CmdCode), 32'(m_code));
    check("InitDone", 32'(InitDone), 32'(m_done));
    check("Pending", 32'(Pending), 32'(m_pend));
    check("Urgent", 32'(Urgent), 32'(m_pend >= MAX_PENDING - 1));
    check("Overflow", 32'(Overflow), 32'(m_ovf));
`ifdef SDRAM_REF_STATS_EN
    check("RefCount", RefCount, 32'(m_refs));
    check("OvfCount", 32'(OvfCount), 32'(m_ovfs));
`endif

    tick_left--;
    if (tick_left <= 0) begin
      TickIn    = ~TickIn;
      tick_left = $urandom_range(3, 5);
    end
  endtask

  task automatic run_init(input bit rand_ack, input int bound);
    for (int i = 0; i < bound && !m_run; i++) begin
      CmdAck = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    CmdAck = 1'b0;
    check("init_done", 32'(InitDone), 32'd1);
    check("init_cmd_count", 32'(acc_log.size()), 32'(INIT_REFRESHES + 2));
    for (int i = 0; i < acc_log.size() && i < INIT_REFRESHES + 2; i++) begin
      check("init_cmd_order", 32'(acc_log[i]),
            (i == 0) ? 32'd1 : ((i == INIT_REFRESHES + 1) ? 32'd3 : 32'd2));
    end
  endtask

  task automatic wait_dues(input int n, input bit ack, input int bound);
    int target;
    int i;
    target = m_dues + n;
    CmdAck = ack;
    for (i = 0; i < bound && m_dues < target; i++) step();
    check("due_wait_timeout", 32'(i < bound), 32'd1);
  endtask

  initial begin
    int i;
    bit predicted;

    Reset  = 1'b1;
    CmdAck = 1'b1;
    step();
    step();
    check("rst_CmdReq", 32'(CmdReq), 32'd0);
    check("rst_Pending", 32'(Pending), 32'd0);
    Reset = 1'b0;

    run_init(1'b0, 3000);

    wait_dues(3, 1'b1, 4000);
    check("run_no_overflow", 32'(Overflow), 32'd0);

    wait_dues(9, 1'b0, 9000);
    step();
    check("held_pending_max", 32'(Pending), 32'(MAX_PENDING));
    check("held_urgent", 32'(Urgent), 32'd1);
    check("held_overflow", 32'(Overflow), 32'd1);
    CmdAck = 1'b1;
    for (i = 0; i < 200 && m_pend != 0; i++) step();
    step();
    check("drained_pending", 32'(Pending), 32'd0);
    check("overflow_sticky", 32'(Overflow), 32'd1);

    CmdAck = 1'b0;
    for (i = 0; i < 4000 && m_pend != 3; i++) step();
    check("reach_pending3", 32'(Pending), 32'd3);
    predicted = 1'b0;
    for (i = 0; i < 1500 && !predicted; i++) begin
      predicted = hist[2] && !hist[3] && ((m_ticks % REF_TICKS) == REF_TICKS - 1);
      CmdAck = predicted;
      step();
    end
    CmdAck = 1'b0;
    check("coincide_found", 32'(predicted), 32'd1);
    check("coincide_pending", 32'(Pending), 32'd3);

    for (i = 0; i < 2500; i++) begin
      CmdAck = ($urandom_range(0, 9) < 3);
      step();
    end

    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (i = 0; i < 3000 && !(!m_wait && !m_run && m_req && cmdq.size() > 2 &&
                              cmdq.size() <= INIT_REFRESHES); i++) begin
      CmdAck = 1'($urandom_range(0, 1));
      step();
    end
    check("mid_init_ref_reached", 32'(CmdReq && CmdCode == 2'b10), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_CmdReq", 32'(CmdReq), 32'd0);
    check("midrst_CmdCode", 32'(CmdCode), 32'd0);
    check("midrst_InitDone", 32'(InitDone), 32'd0);
    check("midrst_Overflow", 32'(Overflow), 32'd0);

    run_init(1'b1, 4000);
    for (i = 0; i < 1500; i++) begin
      CmdAck = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
